// File: rtl/data_mem_unit.sv
// Multi-cycle 16-bit data memory behind the execute ALU.
// One request at a time: IDLE accepts, BUSY counts down, RESP pulses.
module data_mem_unit #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [3:0]  CNT_INI = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;

    logic [15:0] mem [DEPTH];

    logic          accept;
    logic          do_access;
    logic          acc_err;
    logic [AW-1:0] idx;

    assign accept    = (state_q == IDLE) && req_valid;
    assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);
    assign acc_err   = addr_q[0] | ({1'b0, addr_q[15:1]} >= DEPTH_W);
    assign idx       = addr_q[AW:1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INI;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (do_access) begin
                err_q   <= acc_err;
                rdata_q <= (!we_q && !acc_err) ? mem[idx] : 16'h0000;
            end
        end
    end

    // Array is never reset; rst on the final BUSY edge cancels the store.
    always_ff @(posedge clk) begin
        if (!rst && do_access && we_q && !acc_err) begin
            mem[idx] <= wdata_q;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign stall     = ((state_q == IDLE) && req_valid) || (state_q == BUSY);

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit.
// Expected responses come from a bench-side memory model via a queue.
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] rd;
        logic        er;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mdl [0:1023];

    data_mem_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic we, input logic [15:0] a,
                                   input logic [15:0] d);
        exp_t e;
        e.er = a[0] | (a[15:1] >= 15'd1024);
        e.rd = 16'h0000;
        if (!e.er) begin
            if (we) mdl[a[10:1]] = d;
            else    e.rd = mdl[a[10:1]];
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request from IDLE and returns what the DUT did.
    task automatic issue(input logic we, input logic [15:0] a,
                         input logic [15:0] d, output int lat,
                         output int stalls, output logic [15:0] rd,
                         output logic er);
        lat = -1;
        rd  = 16'h0000;
        er  = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        stalls = int'(stall);
        tick;
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            stalls += int'(stall);
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0000;
        req_wdata = 16'hDEAD;
        tick;
        tick;
        #1;
        checks += 5;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", req_ready);
        end
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall got=%b want=1", stall);
        end
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
        end
        if (rsp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata got=%h want=0000", rsp_rdata);
        end
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got=%b want=0", rsp_err);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        tick;
        tick;
        checks += 2;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_accept ready got=%b want=1", req_ready);
        end
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_stall got=%b want=0", stall);
        end
    endtask

    task automatic test_store_load;
        logic        we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] a_t  [4] = '{16'h0000, 16'h0000, 16'h07FE, 16'h07FE};
        logic [15:0] d_t  [4] = '{16'h0007, 16'h0000, 16'hA5A5, 16'h0000};
        exp_t        e;
        int          lat, st;
        logic [15:0] rd;
        logic        er;
        for (int i = 0; i < 4; i++) begin
            sbq.push_back(model(we_t[i], a_t[i], d_t[i]));
            issue(we_t[i], a_t[i], d_t[i], lat, st, rd, er);
            e = sbq.pop_front();
            checks++;
            if (lat !== 3 || st !== 3 || rd !== e.rd || er !== e.er) begin
                errors++;
                $display("FAIL store_load[%0d] lat=%0d stall=%0d rd=%h err=%b want lat=3 stall=3 rd=%h err=%b",
                         i, lat, st, rd, er, e.rd, e.er);
            end
        end
    endtask

    task automatic test_misaligned;
        logic        we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] a_t  [4] = '{16'h0002, 16'h0003, 16'h0003, 16'h0002};
        logic [15:0] d_t  [4] = '{16'h1111, 16'h0000, 16'h2222, 16'h0000};
        exp_t        e;
        int          lat, st;
        logic [15:0] rd;
        logic        er;
        for (int i = 0; i < 4; i++) begin
            sbq.push_back(model(we_t[i], a_t[i], d_t[i]));
            issue(we_t[i], a_t[i], d_t[i], lat, st, rd, er);
            e = sbq.pop_front();
            checks++;
            if (lat !== 3 || rd !== e.rd || er !== e.er) begin
                errors++;
                $display("FAIL misaligned[%0d] lat=%0d rd=%h err=%b want lat=3 rd=%h err=%b",
                         i, lat, rd, er, e.rd, e.er);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic        we_t [3] = '{1'b1, 1'b0, 1'b0};
        logic [15:0] a_t  [3] = '{16'h0800, 16'h0000, 16'hFFFE};
        logic [15:0] d_t  [3] = '{16'h1234, 16'h0000, 16'h0000};
        exp_t        e;
        int          lat, st;
        logic [15:0] rd;
        logic        er;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back(model(we_t[i], a_t[i], d_t[i]));
            issue(we_t[i], a_t[i], d_t[i], lat, st, rd, er);
            e = sbq.pop_front();
            checks++;
            if (lat !== 3 || rd !== e.rd || er !== e.er) begin
                errors++;
                $display("FAIL out_of_range[%0d] lat=%0d rd=%h err=%b want lat=3 rd=%h err=%b",
                         i, lat, rd, er, e.rd, e.er);
            end
        end
    endtask

    task automatic test_reset_busy;
        exp_t        e;
        int          lat, st, nrsp;
        logic [15:0] rd;
        logic        er;
        sbq.push_back(model(1'b1, 16'h0004, 16'h5555));
        issue(1'b1, 16'h0004, 16'h5555, lat, st, rd, er);
        e = sbq.pop_front();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0004;
        req_wdata = 16'hBEEF;
        tick;
        req_valid = 1'b0;
        rst       = 1'b1;
        tick;
        rst  = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid === 1'b1) nrsp++;
            tick;
        end
        checks += 2;
        if (nrsp !== 0) begin
            errors++;
            $display("FAIL reset_busy_rsp got=%0d pulses want=0", nrsp);
        end
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_ready got=%b want=1", req_ready);
        end
        sbq.push_back(model(1'b0, 16'h0004, 16'h0000));
        issue(1'b0, 16'h0004, 16'h0000, lat, st, rd, er);
        e = sbq.pop_front();
        checks++;
        if (lat !== 3 || rd !== e.rd || er !== e.er) begin
            errors++;
            $display("FAIL reset_busy_load lat=%0d rd=%h err=%b want lat=3 rd=%h err=%b",
                     lat, rd, er, e.rd, e.er);
        end
    endtask

    task automatic test_busy_ignore;
        exp_t        e;
        int          lat, st, nrsp, nbad;
        logic [15:0] rd;
        logic        er;
        sbq.push_back(model(1'b1, 16'h0006, 16'h0ABC));
        sbq.push_back(model(1'b1, 16'h0008, 16'h0DEF));
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0006;
        req_wdata = 16'h0ABC;
        tick;
        req_addr  = 16'h0008;
        req_wdata = 16'h0DEF;
        nrsp = 0;
        nbad = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) req_valid = 1'b0;
            #1;
            if (k <= 3 && req_ready !== 1'b0) nbad++;
            if (k == 4 && req_ready !== 1'b1) nbad++;
            if (rsp_valid === 1'b1) begin
                nrsp++;
                e = sbq.pop_front();
                checks++;
                if (k !== (nrsp == 1 ? 3 : 7) || rsp_err !== e.er
                    || rsp_rdata !== e.rd) begin
                    errors++;
                    $display("FAIL busy_ignore_rsp%0d cycle=%0d err=%b want cycle=%0d err=%b",
                             nrsp, k, rsp_err, (nrsp == 1 ? 3 : 7), e.er);
                end
            end
            tick;
        end
        checks += 2;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL busy_ignore_ready got=%0d bad cycles want=0", nbad);
        end
        if (nrsp !== 2) begin
            errors++;
            $display("FAIL busy_ignore_count got=%0d want=2", nrsp);
            sbq.delete();
        end
        for (int i = 0; i < 2; i++) begin
            logic [15:0] a;
            a = (i == 0) ? 16'h0006 : 16'h0008;
            sbq.push_back(model(1'b0, a, 16'h0000));
            issue(1'b0, a, 16'h0000, lat, st, rd, er);
            e = sbq.pop_front();
            checks++;
            if (rd !== e.rd || er !== e.er) begin
                errors++;
                $display("FAIL busy_ignore_load[%0d] rd=%h err=%b want rd=%h err=%b",
                         i, rd, er, e.rd, e.er);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        int          lat, st;
        logic [15:0] rd;
        logic        er;
        logic [15:0] a;
        logic [15:0] d;
        for (int i = 0; i < 12; i++) begin
            a = 16'h0100 + 16'((i % 6) * 2);
            d = 16'($urandom);
            sbq.push_back(model(i < 6, a, d));
            issue(i < 6, a, d, lat, st, rd, er);
            e = sbq.pop_front();
            checks++;
            if (lat !== 3 || st !== 3 || rd !== e.rd || er !== e.er) begin
                errors++;
                $display("FAIL back_to_back[%0d] lat=%0d stall=%0d rd=%h err=%b want lat=3 stall=3 rd=%h err=%b",
                         i, lat, st, rd, er, e.rd, e.er);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        test_reset;
        test_store_load;
        test_misaligned;
        test_out_of_range;
        test_reset_busy;
        test_busy_ignore;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
